// File: rtl/sd_pkg.sv
// Shared definitions for the sigma-delta DAC modulator and its decimator:
// output width, CIC internal width and decimator state encoding.
package sd_pkg;

  localparam int DOUT_W = 16;

  // Bit growth of an order-N CIC with ratio 2^L is N*L; one extra bit
  // represents the all-ones window exactly.
  function automatic int cic_width(input int order, input int dec_log2);
    return order * dec_log2 + 1;
  endfunction

  typedef enum logic {
    ST_WARMUP = 1'b0,
    ST_RUN    = 1'b1
  } sd_state_e;

endpackage

// File: rtl/sd_cic_comb.sv
// One CIC comb stage: y = x - x_prev, where the delay advances only when enabled.
module sd_cic_comb #(
  parameter int W = 21
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [W-1:0] x_i,
  output logic [W-1:0] y_o
);

  logic [W-1:0] x_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_prev_q <= '0;
    end else if (en_i) begin
      x_prev_q <= x_i;
    end
  end

  assign y_o = x_i - x_prev_q;

endmodule

// File: rtl/sd_decimator.sv
// Sigma-delta bitstream decimator: an order-N CIC with ratio 2^DEC_LOG2 that
// turns a unipolar pulse-density stream back into 16-bit PCM samples.
module sd_decimator
  import sd_pkg::*;
#(
  parameter int ORDER    = 2,
  parameter int DEC_LOG2 = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              din_valid,
  output logic [DOUT_W-1:0] dout,
  output logic              dout_valid
);

  localparam int W      = cic_width(ORDER, DEC_LOG2);
  localparam int WARM_W = $clog2(ORDER + 1);

  logic [W-1:0]        integ_q [ORDER];
  logic [W-1:0]        integ_d [ORDER];
  logic [W-1:0]        comb_x  [ORDER+1];
  logic [DEC_LOG2-1:0] dec_cnt_q;
  logic [WARM_W-1:0]   warm_cnt_q;
  sd_state_e           state_q;
  logic [DOUT_W-1:0]   dout_q;
  logic [DOUT_W-1:0]   dout_d;
  logic                dout_valid_q;
  logic                tick;

  assign tick = din_valid && (dec_cnt_q == '1);

  genvar gi;
  generate
    for (gi = 0; gi < ORDER; gi++) begin : g_integ
      if (gi == 0) begin : g_first
        assign integ_d[gi] = integ_q[gi] + W'(din);
      end else begin : g_next
        assign integ_d[gi] = integ_q[gi] + integ_d[gi-1];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          integ_q[gi] <= '0;
        end else if (din_valid) begin
          integ_q[gi] <= integ_d[gi];
        end
      end
    end
  endgenerate

  // The comb chain sees the final integrator's post-update value on the tick edge.
  assign comb_x[0] = integ_d[ORDER-1];

  generate
    for (gi = 0; gi < ORDER; gi++) begin : g_comb
      sd_cic_comb #(
        .W (W)
      ) u_comb (
        .clk  (clk),
        .rst  (rst),
        .en_i (tick),
        .x_i  (comb_x[gi]),
        .y_o  (comb_x[gi+1])
      );
    end
  endgenerate

  // Full-scale result R^ORDER only sets the top bit; clamp it to all-ones.
  always_comb begin
    dout_d = DOUT_W'(comb_x[ORDER] >> (W - 1 - DOUT_W));
    if (comb_x[ORDER][W-1]) begin
      dout_d = '1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_cnt_q    <= '0;
      warm_cnt_q   <= '0;
      state_q      <= ST_WARMUP;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      if (din_valid) begin
        dec_cnt_q <= dec_cnt_q + 1'b1;
      end
      if (tick) begin
        case (state_q)
          ST_WARMUP: begin
            warm_cnt_q <= warm_cnt_q + 1'b1;
            if (warm_cnt_q == WARM_W'(ORDER - 1)) begin
              state_q <= ST_RUN;
            end
          end
          ST_RUN: begin
            dout_q       <= dout_d;
            dout_valid_q <= 1'b1;
          end
          default: state_q <= ST_WARMUP;
        endcase
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_sd_decimator.sv
// Randomised bench for sd_decimator: a sinc^N impulse-response model over the
// accepted bit history predicts every strobe and every held dout value.
module tb_sd_decimator;

  localparam int ORDER    = 2;
  localparam int DEC_LOG2 = 10;
  localparam int R        = 1 << DEC_LOG2;
  localparam int W        = ORDER * DEC_LOG2 + 1;
  localparam int HLEN     = ORDER * (R - 1) + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din = 1'b0;
  logic        din_valid = 1'b0;
  logic [15:0] dout;
  logic        dout_valid;

  int          n_tests = 0;
  int          n_fail  = 0;

  longint      h [HLEN];
  longint      h_tmp [HLEN];
  bit          hist[$];
  logic        exp_valid = 1'b0;
  logic [15:0] exp_dout  = 16'h0000;
  logic        tog = 1'b0;
  logic [15:0] dac_acc = 16'h0000;

  sd_decimator #(
    .ORDER    (ORDER),
    .DEC_LOG2 (DEC_LOG2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // CIC output = accepted history convolved with N cascaded length-R boxcars.
  function automatic longint window_sum();
    longint c = 0;
    int     e = hist.size() - 1;
    for (int j = 0; j < HLEN && j <= e; j++) begin
      if (hist[e-j]) c += h[j];
    end
    return c;
  endfunction

  function automatic logic [15:0] scale(input longint c);
    if (c >= (longint'(1) << (W - 1))) return 16'hFFFF;
    return 16'(c >> (W - 17));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      hist.delete();
      exp_valid = 1'b0;
      exp_dout  = 16'h0000;
    end else begin
      exp_valid = 1'b0;
      if (din_valid) begin
        hist.push_back(din);
        if ((hist.size() % R) == 0 && (hist.size() / R) > ORDER) begin
          exp_dout  = scale(window_sum());
          exp_valid = 1'b1;
        end
      end
    end
    #1;
    check("dout_valid", {31'b0, dout_valid}, {31'b0, exp_valid});
    check("dout", {16'b0, dout}, {16'b0, exp_dout});
  end

  // mode 0: zeros, 1: ones, 2: 1,0 toggle, 3: first-order DAC of code
  function automatic logic next_bit(input int mode, input logic [15:0] code);
    logic b;
    case (mode)
      0: b = 1'b0;
      1: b = 1'b1;
      2: begin tog = ~tog; b = tog; end
      default: {b, dac_acc} = {1'b0, dac_acc} + {1'b0, code};
    endcase
    return b;
  endfunction

  task automatic drive(input int nbits, input int mode, input logic [15:0] code, input int gap_pct);
    int sent = 0;
    while (sent < nbits) begin
      @(negedge clk);
      if (int'($urandom_range(99)) < gap_pct) begin
        din_valid = 1'b0;
        din       = 1'($urandom_range(1));
      end else begin
        din_valid = 1'b1;
        din       = next_bit(mode, code);
        sent++;
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    din_valid = 1'b0;
    din       = 1'b0;
  endtask

  initial begin
    logic [15:0] code;
    int          diff;

    for (int j = 0; j < HLEN; j++) h[j] = (j < R) ? 1 : 0;
    for (int s = 1; s < ORDER; s++) begin
      for (int j = 0; j < HLEN; j++) h_tmp[j] = 0;
      for (int i = 0; i < HLEN; i++) begin
        if (h[i] != 0) begin
          for (int k = 0; k < R && i + k < HLEN; k++) h_tmp[i+k] += h[i];
        end
      end
      for (int j = 0; j < HLEN; j++) h[j] = h_tmp[j];
    end

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_dout", {16'b0, dout}, 32'h0);
    check("rst_valid", {31'b0, dout_valid}, 32'h0);

    drive(4 * R, 0, 16'h0, 0);  settle();
    check("const0", {16'b0, dout}, 32'h0000);
    drive(4 * R, 1, 16'h0, 0);  settle();
    check("const1", {16'b0, dout}, 32'hFFFF);
    tog = 1'b0;
    drive(4 * R, 2, 16'h0, 0);  settle();
    check("toggle", {16'b0, dout}, 32'h8000);
    dac_acc = 16'h0;
    drive(4 * R, 3, 16'h4000, 0);  settle();
    check("dac_4000", {16'b0, dout}, 32'h4000);
    drive(4 * R, 2, 16'h0, 50);  settle();
    check("toggle_gaps", {16'b0, dout}, 32'h8000);

    drive(R + 500, 2, 16'h0, 0);
    @(negedge clk);
    rst = 1'b1;  din_valid = 1'b1;  din = 1'b1;
    @(negedge clk);
    rst = 1'b0;  din_valid = 1'b0;  din = 1'b0;
    check("midrst_dout", {16'b0, dout}, 32'h0);
    check("midrst_valid", {31'b0, dout_valid}, 32'h0);
    drive(4 * R, 2, 16'h0, 0);  settle();
    check("post_rst", {16'b0, dout}, 32'h8000);

    // Codes on a 64-LSB grid repeat with a period dividing R, so a settled window is exact.
    for (int n = 0; n < 6; n++) begin
      code = 16'($urandom_range(1023) << 6);
      drive(3 * R, 3, code, 0);  settle();
      diff = int'(dout) - int'(code);
      if (diff < 0) diff = -diff;
      check("dac_sweep", {31'b0, diff <= 2}, 32'h1);
    end

    for (int n = 0; n < 3; n++) begin
      code = 16'($urandom_range(16'hFFFF));
      drive(2 * R, 3, code, 25);  settle();
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
